// File: rtl/debug_port_arbiter.sv
// rtl/debug_port_arbiter.sv - round-robin debug write port arbiter with halt sequencing
// One holding slot per requester feeds a registered output stage; a halt write drains last and locks the port.
module debug_port_arbiter #(
  parameter int unsigned       N_REQ     = 4,
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 24'h000004
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [63:0]               tick_cntr_i,
  output logic                      dbg_en_o,
  output logic                      dbg_we_o,
  output logic [ADDR_W-1:0]         dbg_addr_o,
  output logic [DATA_W-1:0]         dbg_data_o,
  output logic [63:0]               dbg_tick_o,
  input  logic                      dbg_ready_i,
  output logic                      halt_pending_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e state_q, state_d;

  logic [N_REQ-1:0]  slot_valid_q;
  logic [ADDR_W-1:0] slot_addr_q [N_REQ];
  logic [DATA_W-1:0] slot_data_q [N_REQ];
  logic [63:0]       slot_tick_q [N_REQ];
  logic [PTR_W-1:0]  rr_ptr_q;

  logic              out_valid_q;
  logic              out_halt_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [63:0]       out_tick_q;

  logic [N_REQ-1:0]  is_halt;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pop;
  logic [N_REQ-1:0]  accept;
  logic              any_nonhalt;
  logic              any_halt;
  logic              grant_en;
  logic              load_out;
  logic              found;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  next_ptr;
  logic [SUM_W-1:0]  sum;
  logic [PTR_W-1:0]  idx;

  // A halt slot waits until no log write is pending, so it always leaves last.
  always_comb begin
    is_halt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      is_halt[i] = slot_valid_q[i] & (slot_addr_q[i] == HALT_ADDR);
    end
    any_nonhalt = |(slot_valid_q & ~is_halt);
    any_halt    = |is_halt;
    eligible    = slot_valid_q & ~(is_halt & {N_REQ{any_nonhalt}});
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) begin
        sum = sum - SUM_W'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Once a halt sits in the output stage nothing else may follow it, including a second halt.
  assign grant_en = (state_q != ST_HALTED) & ~(out_valid_q & out_halt_q);
  assign load_out = grant_en & found & (~out_valid_q | dbg_ready_i);
  assign next_ptr = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pop[i] = load_out & (winner == PTR_W'(i));
    end
  end

  assign req_ready_o = (rst_ni && state_q == ST_RUN) ? (~slot_valid_q | pop) : '0;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (any_halt || (out_valid_q && out_halt_q)) state_d = ST_DRAIN;
      ST_DRAIN:  if (out_valid_q && out_halt_q && dbg_ready_i) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
        slot_tick_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          slot_valid_q[i] <= 1'b1;
          slot_addr_q[i]  <= req_addr_i[i*ADDR_W +: ADDR_W];
          slot_data_q[i]  <= req_data_i[i*DATA_W +: DATA_W];
          slot_tick_q[i]  <= tick_cntr_i;
        end else if (pop[i]) begin
          slot_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_halt_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_tick_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_halt_q  <= is_halt[winner];
      out_addr_q  <= slot_addr_q[winner];
      out_data_q  <= slot_data_q[winner];
      out_tick_q  <= slot_tick_q[winner];
      rr_ptr_q    <= next_ptr;
    end else if (dbg_ready_i) begin
      out_valid_q <= 1'b0;
      out_halt_q  <= 1'b0;
    end
  end

  assign dbg_en_o       = out_valid_q;
  assign dbg_we_o       = out_valid_q;
  assign dbg_addr_o     = out_addr_q;
  assign dbg_data_o     = out_data_q;
  assign dbg_tick_o     = out_tick_q;
  assign halt_pending_o = (state_q == ST_DRAIN);

endmodule
